bcd_serial_adder: RTL and testbench
===================================

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 4, the maximum number of digit beats per operand pair.
REQ-002 SHALL have port Clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  the digit pair on a_digit/b_digit is valid.
REQ-005 SHALL have port in_ready  output  1  the block accepts a digit pair this cycle.
REQ-006 SHALL have port a_digit  input  4  operand A BCD digit, least-significant digit first.
REQ-007 SHALL have port b_digit  input  4  operand B BCD digit, least-significant digit first.
REQ-008 SHALL have port in_last  input  1  the current beat is the most-significant digit pair.
REQ-009 SHALL have port out_valid  output  1  sum_digit is valid.
REQ-010 SHALL have port out_ready  input  1  the downstream stage accepts the output this cycle.
REQ-011 SHALL have port sum_digit  output  4  BCD sum digit.
REQ-012 SHALL have port out_last  output  1  sum_digit is the final digit of the result.
REQ-013 SHALL have port err  output  1  sticky error flag for the current result.

Function
REQ-014 SHALL transfer an input beat when in_valid and in_ready are both 1, and an output beat when out_valid and out_ready are both 1.
REQ-015 SHALL drive in_ready = (state != S_CARRY) and (!out_valid or out_ready).
REQ-016 SHALL register each result digit, giving 1-cycle latency from input transfer to out_valid.
REQ-017 SHALL form raw = a_digit + b_digit + carry (5 bits); if raw > 9, sum_digit = raw + 6 (low 4 bits) and next carry = 1; otherwise sum_digit = raw and next carry = 0.
REQ-018 SHALL implement the FSM states S_IDLE, S_RUN and S_CARRY.
REQ-019 SHALL move from S_IDLE or S_RUN to S_RUN on a non-final beat.
REQ-020 SHALL move to S_IDLE on a final beat that produces no carry, with out_last = 1 on that digit.
REQ-021 SHALL move to S_CARRY on a final beat that produces a carry, with out_last = 0 on that digit.
REQ-022 SHALL, in S_CARRY, emit sum_digit = 1 with out_last = 1 once the previous output has transferred, then return to S_IDLE with carry = 0.
REQ-023 SHALL treat a beat as final when in_last = 1 or when the digit count reaches MAX_DIGITS; a forced final beat (in_last = 0) SHALL set err.
REQ-024 SHALL hold out_valid, sum_digit, out_last and err stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL clear err and the digit count when the output beat with out_last = 1 transfers.

Reset
REQ-026 SHALL, while Resetn = 0, force state = S_IDLE, carry = 0, digit count = 0, out_valid = 0, sum_digit = 0, out_last = 0 and err = 0.
REQ-027 SHALL, on reset asserted mid-operand, discard the partial result, with no output beat following reset release until new input arrives.

Configuration
REQ-028 SHALL, with BCD_SERIAL_ADDER_CHECK_EN defined, set err when an accepted a_digit or b_digit exceeds 9, while still computing the sum per REQ-017.
REQ-029 SHALL, without BCD_SERIAL_ADDER_CHECK_EN, perform no digit-range check, so err reflects only REQ-023.

Structure
REQ-030 SHALL place the state encodings (S_IDLE, S_RUN, S_CARRY), the BCD limit constant 9 and the correction constant 6 in a shared package.
REQ-031 SHALL implement the combinational digit add and correction of REQ-017 as sub-module bcd_digit_add (inputs a, b, cin; outputs s, cout).

Verification
REQ-032 SHALL cover 0457 + 0368 with beats (7,8), (5,6), (4,3), (0,0, last) -> outputs 5, 2, 8, 0 with last on 0 and err = 0.
REQ-033 SHALL cover single beat (9,1, last) -> output 0 (last = 0) followed by 1 (last = 1), with in_ready = 0 during S_CARRY.
REQ-034 SHALL cover holding out_ready = 0 for 3 cycles mid-stream -> in_ready = 0 and the output held stable, with no digit lost or duplicated.
REQ-035 SHALL cover 5 beats with no in_last and MAX_DIGITS = 4 -> 4th output has last = 1 and err = 1, and the 5th beat starts a new result.
REQ-036 SHALL cover, with BCD_SERIAL_ADDER_CHECK_EN defined, beat (0xC, 0x1, last) -> err = 1 on that output.
REQ-037 SHALL cover asserting Resetn = 0 after 2 beats, then applying (2,3, last) -> a single output 5 with last = 1 and carry = 0.

Source files
------------

// File: rtl/bcd_serial_adder_pkg.sv
// rtl/bcd_serial_adder_pkg.sv - shared state encoding and BCD constants for the serial adder
package bcd_serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CARRY = 2'd2
  } state_t;

  localparam logic [4:0] BCD_MAX = 5'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - single BCD digit add with decimal correction
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout = (raw > BCD_MAX);
    // Adding 6 skips the six unused codes so the low nibble wraps to the decimal digit.
    s    = cout ? (raw[3:0] + BCD_ADJ) : raw[3:0];
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - serial LSD-first BCD adder with ready/valid digit streams
// Define BCD_SERIAL_ADDER_CHECK_EN to flag accepted operand digits above 9 on err.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int MAX_DIGITS = 4
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a_digit,
  input  logic [3:0] b_digit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] sum_digit,
  output logic       out_last,
  output logic       err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

  state_t          state;
  state_t          state_next;
  logic            carry;
  logic [CW-1:0]   dcnt;
  logic [CW-1:0]   cnt_base;
  logic [CW-1:0]   cnt_inc;
  logic            in_fire;
  logic            out_fire;
  logic            slot_free;
  logic            final_beat;
  logic            forced_final;
  logic            carry_emit;
  logic            digit_err;
  logic            err_base;
  logic [3:0]      add_sum;
  logic            add_cout;

  bcd_digit_add u_digit_add (
    .a    (a_digit),
    .b    (b_digit),
    .cin  (carry),
    .s    (add_sum),
    .cout (add_cout)
  );

  assign slot_free = !out_valid || out_ready;
  assign out_fire  = out_valid && out_ready;
  assign in_fire   = in_valid && in_ready;

  // A result closing on this very edge frees the count and err for a beat accepted alongside it.
  assign cnt_base     = (out_fire && out_last) ? '0 : dcnt;
  assign err_base     = (out_fire && out_last) ? 1'b0 : err;
  assign cnt_inc      = cnt_base + CW'(1);
  assign final_beat   = in_last || (cnt_inc == MAX_CNT);
  assign forced_final = final_beat && !in_last;

`ifdef BCD_SERIAL_ADDER_CHECK_EN
  assign digit_err = ({1'b0, a_digit} > BCD_MAX) || ({1'b0, b_digit} > BCD_MAX);
`else
  assign digit_err = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_RUN: begin
        if (in_fire) begin
          if (!final_beat) begin
            state_next = S_RUN;
          end else if (add_cout) begin
            state_next = S_CARRY;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_CARRY: begin
        if (slot_free) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    carry_emit = 1'b0;
    case (state)
      S_IDLE, S_RUN: in_ready   = slot_free;
      S_CARRY:       carry_emit = slot_free;
      default: begin
        in_ready   = 1'b0;
        carry_emit = 1'b0;
      end
    endcase
  end

  // Output register only reloads when the slot is empty or draining, so held beats stay stable.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      carry     <= 1'b0;
      dcnt      <= '0;
      out_valid <= 1'b0;
      sum_digit <= 4'd0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      sum_digit <= add_sum;
      out_last  <= final_beat && !add_cout;
      err       <= err_base || forced_final || digit_err;
      carry     <= add_cout;
      dcnt      <= cnt_inc;
    end else if (carry_emit) begin
      out_valid <= 1'b1;
      sum_digit <= 4'd1;
      out_last  <= 1'b1;
      err       <= err_base;
      carry     <= 1'b0;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      if (out_last) begin
        err  <= 1'b0;
        dcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - self-checking bench for bcd_serial_adder against a decimal-arithmetic model
module tb_bcd_serial_adder;

  localparam int MAXD = 4;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a_digit = 4'd0;
  logic [3:0] b_digit = 4'd0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] sum_digit;
  logic       out_last;
  logic       err;

  int checks = 0;
  int errors = 0;
  bit rand_rdy = 1'b0;

  logic [5:0] obs_q[$];
  logic [5:0] exp_q[$];
  int qa[$];
  int qb[$];
  bit ql[$];
  int ca[$];
  int cb[$];

  always #5 Clock = ~Clock;

  bcd_serial_adder #(.MAX_DIGITS(MAXD)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_digit   (a_digit),
    .b_digit   (b_digit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_digit (sum_digit),
    .out_last  (out_last),
    .err       (err)
  );

  // Output monitor: every transferred beat as {err, last, digit}.
  always @(negedge Clock) begin
    if (Resetn && out_valid && out_ready) obs_q.push_back({err, out_last, sum_digit});
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a result's digits are the decimal digits of A+B, with one extra digit if it overflows.
  task automatic close_result(input bit forced);
    int av = 0;
    int bv = 0;
    int s;
    int p = 1;
    int n;
    logic [3:0] dg;
    n = ca.size();
    for (int i = 0; i < n; i++) begin
      av += ca[i] * p;
      bv += cb[i] * p;
      p  *= 10;
    end
    s = av + bv;
    p = 1;
    for (int i = 0; i < n; i++) begin
      dg = 4'((s / p) % 10);
      exp_q.push_back({forced && (i == n - 1), (i == n - 1) && (s < 10 ** n), dg});
      p *= 10;
    end
    if (s >= 10 ** n) exp_q.push_back({forced, 1'b1, 4'd1});
  endtask

  task automatic build_expected();
    exp_q.delete();
    ca.delete();
    cb.delete();
    foreach (qa[i]) begin
      ca.push_back(qa[i]);
      cb.push_back(qb[i]);
      if (ql[i] || ca.size() == MAXD) begin
        close_result(!ql[i]);
        ca.delete();
        cb.delete();
      end
    end
  endtask

  task automatic add_beat(input int a, input int b, input bit last);
    qa.push_back(a);
    qb.push_back(b);
    ql.push_back(last);
  endtask

  task automatic send_beat(input int a, input int b, input bit last);
    bit done = 1'b0;
    a_digit  = 4'(a);
    b_digit  = 4'(b);
    in_last  = last;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge Clock);
      done = in_ready;
      @(posedge Clock);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("accept", done, 1);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_beat(qa[i], qb[i], ql[i]);
  endtask

  task automatic drain();
    bit idle = 1'b0;
    for (int t = 0; t < 200 && !idle; t++) begin
      @(negedge Clock);
      idle = !out_valid;
      if (!idle) begin
        @(posedge Clock);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        else out_ready = 1'b1;
      end
    end
    check("drain", idle, 1);
    @(posedge Clock);
    #1;
    out_ready = 1'b1;
  endtask

  task automatic compare_case(input string tag);
    build_expected();
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    qa.delete();
    qb.delete();
    ql.delete();
  endtask

  initial begin
    logic [5:0] held;
    int len;

    // Reset state
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum_digit", sum_digit, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge Clock);
    #1;
    Resetn    = 1'b1;
    out_ready = 1'b1;

    // 0457 + 0368 = 0825
    add_beat(7, 8, 0); add_beat(5, 6, 0); add_beat(4, 3, 0); add_beat(0, 0, 1);
    send_range(0, 3);
    drain();
    check("d457_n", obs_q.size(), 4);
    check("d457_0", obs_q[0], 6'h05);
    check("d457_1", obs_q[1], 6'h02);
    check("d457_2", obs_q[2], 6'h08);
    check("d457_3", obs_q[3], 6'h10);
    compare_case("d457");

    // 9 + 1: carry digit, input stalled while it is emitted
    add_beat(9, 1, 1);
    send_range(0, 0);
    @(negedge Clock);
    check("carry_in_ready", in_ready, 0);
    @(posedge Clock);
    #1;
    drain();
    check("c91_0", obs_q[0], 6'h00);
    check("c91_1", obs_q[1], 6'h11);
    compare_case("c91");

    // Downstream stall mid-stream
    for (int i = 0; i < 4; i++) add_beat($urandom_range(0, 9), $urandom_range(0, 9), i == 3);
    send_range(0, 1);
    out_ready = 1'b0;
    held = {err, out_last, sum_digit};
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_hold", {err, out_last, sum_digit}, held);
      @(posedge Clock);
      #1;
    end
    out_ready = 1'b1;
    send_range(2, 3);
    drain();
    compare_case("stall");

    // Five beats without in_last: forced close after MAX_DIGITS, fifth starts a new result
    for (int i = 0; i < 6; i++) add_beat($urandom_range(0, 4), $urandom_range(0, 4), i == 5);
    send_range(0, 5);
    drain();
    check("force_last_err", obs_q[3][5:4], 2'b11);
    check("force_new_err", obs_q[4][5], 0);
    compare_case("force");

    // Randomised results with random downstream backpressure
    rand_rdy = 1'b1;
    for (int r = 0; r < 16; r++) begin
      len = $urandom_range(1, MAXD);
      for (int i = 0; i < len; i++) add_beat($urandom_range(0, 9), $urandom_range(0, 9), i == len - 1);
    end
    send_range(0, qa.size() - 1);
    drain();
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    compare_case("rand");

    // Reset mid-operand with a pending carry
    add_beat(9, 9, 0); add_beat(9, 9, 0);
    send_range(0, 1);
    Resetn = 1'b0;
    @(negedge Clock);
    check("midrst_out_valid", out_valid, 0);
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    obs_q.delete(); qa.delete(); qb.delete(); ql.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      check("postrst_quiet", out_valid, 0);
    end
    @(posedge Clock);
    #1;
    add_beat(2, 3, 1);
    send_range(0, 0);
    drain();
    check("postrst_n", obs_q.size(), 1);
    check("postrst_0", obs_q[0], 6'h15);
    compare_case("postrst");

`ifdef BCD_SERIAL_ADDER_CHECK_EN
    add_beat(12, 1, 1);
    send_range(0, 0);
    drain();
    check("range_err", obs_q[0][5], 1);
    check("range_digit", obs_q[0][3:0], 4'd3);
    check("range_carry", obs_q[1], 6'h31);
    obs_q.delete(); qa.delete(); qb.delete(); ql.delete();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
